uart_score_reporter: RTL and testbench

Upstream feeder for the 9600-baud UART byte transmitter. On request it latches a 16-bit game score, converts it to five ASCII decimal digits, and hands a fixed 9-byte line (prefix, '=', five digits, CR, LF) to the transmitter one byte at a time through its SEND/DATA/READY handshake. It sits between game logic, which pulses START, and the transmitter, which sends the bytes out on UART_TX.

---
 rtl/uart_score_reporter.sv | 128 ++++++++++++
 tb/tb_uart_score_reporter.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_score_reporter.sv
// Latches a 16-bit score, converts it to five ASCII digits with double-dabble and
// feeds the 9-byte line "S=ddddd\r\n" to a UART transmitter over SEND/DATA/READY.
module uart_score_reporter #(
   parameter logic [7:0] PREFIX_CHAR = 8'h53,
   parameter logic [7:0] SEP_CHAR    = 8'h3D
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic [15:0] SCORE,
   input  logic        START,
   input  logic        TX_READY,
   output logic        TX_SEND,
   output logic [7:0]  TX_DATA,
   output logic        BUSY,
   output logic        DONE
);

   typedef enum logic [2:0] {
      IDLE,
      CONVERT,
      WAIT_RDY,
      SEND,
      HOLD,
      FINISH
   } stateT;

   stateT       state;
   logic [15:0] binReg;
   logic [19:0] bcdReg;
   logic [3:0]  iterCount;
   logic [3:0]  byteIndex;
   logic [19:0] bcdAdj;
   logic [35:0] shiftVal;
   logic [7:0]  nextByte;

   // Double-dabble step: add 3 to every digit >= 5, then shift {bcd, bin} left by one.
   always_comb begin
      bcdAdj = bcdReg;
      for (int d = 0; d < 5; d++) begin
         if (bcdReg[d*4 +: 4] >= 4'd5) begin
            bcdAdj[d*4 +: 4] = bcdReg[d*4 +: 4] + 4'd3;
         end
      end
      shiftVal = {bcdAdj, binReg} << 1;
   end

   // Byte to send for the current position in the line; digits are most significant first.
   always_comb begin
      nextByte = 8'h00;
      case (byteIndex)
         4'd0:    nextByte = PREFIX_CHAR;
         4'd1:    nextByte = SEP_CHAR;
         4'd2:    nextByte = {4'h3, bcdReg[19:16]};
         4'd3:    nextByte = {4'h3, bcdReg[15:12]};
         4'd4:    nextByte = {4'h3, bcdReg[11:8]};
         4'd5:    nextByte = {4'h3, bcdReg[7:4]};
         4'd6:    nextByte = {4'h3, bcdReg[3:0]};
         4'd7:    nextByte = 8'h0D;
         4'd8:    nextByte = 8'h0A;
         default: nextByte = 8'h00;
      endcase
   end

   // Outputs are registered alongside the state so TX_SEND tracks SEND and DONE tracks FINISH.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state     <= IDLE;
         binReg    <= 16'd0;
         bcdReg    <= 20'd0;
         iterCount <= 4'd0;
         byteIndex <= 4'd0;
         TX_SEND   <= 1'b0;
         TX_DATA   <= 8'h00;
         BUSY      <= 1'b0;
         DONE      <= 1'b0;
      end else begin
         TX_SEND <= 1'b0;
         DONE    <= 1'b0;
         case (state)
            IDLE: begin
               if (START) begin
                  binReg    <= SCORE;
                  bcdReg    <= 20'd0;
                  iterCount <= 4'd0;
                  byteIndex <= 4'd0;
                  BUSY      <= 1'b1;
                  state     <= CONVERT;
               end
            end
            CONVERT: begin
               {bcdReg, binReg} <= shiftVal;
               iterCount        <= iterCount + 4'd1;
               if (iterCount == 4'd15) begin
                  state <= WAIT_RDY;
               end
            end
            WAIT_RDY: begin
               if (TX_READY) begin
                  TX_DATA <= nextByte;
                  TX_SEND <= 1'b1;
                  state   <= SEND;
               end
            end
            SEND: begin
               state <= HOLD;
            end
            // READY is not looked at here; the transmitter drops it only after sampling SEND.
            HOLD: begin
               if (byteIndex == 4'd8) begin
                  DONE  <= 1'b1;
                  state <= FINISH;
               end else begin
                  byteIndex <= byteIndex + 4'd1;
                  state     <= WAIT_RDY;
               end
            end
            FINISH: begin
               BUSY  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_score_reporter.sv
// Self-checking bench for uart_score_reporter: expected line bytes are queued when a
// request is issued and popped as the reporter strobes each byte out.
module tb_uart_score_reporter;

   logic        CLK;
   logic        RST_N;
   logic [15:0] SCORE;
   logic        START;
   logic        TX_READY;
   logic        TX_SEND;
   logic [7:0]  TX_DATA;
   logic        BUSY;
   logic        DONE;

   logic        readyLevel;
   logic        useModel;
   logic        modelReady;
   int          modelCount;

   int checks;
   int failures;

   logic [7:0] expQ[$];
   logic [7:0] obsBytes[$];
   int         obsCycles[$];
   logic       obsReady[$];
   int         doneCycle;
   int         doneCount;
   logic       busyDropped;
   logic       busyAfterDone;

   uart_score_reporter dut (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .SCORE    (SCORE),
      .START    (START),
      .TX_READY (TX_READY),
      .TX_SEND  (TX_SEND),
      .TX_DATA  (TX_DATA),
      .BUSY     (BUSY),
      .DONE     (DONE)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   assign TX_READY = useModel ? modelReady : readyLevel;

   // Shortened transmitter: READY drops the cycle after it samples SEND, returns 8 cycles later.
   always @(posedge CLK) begin
      if (!RST_N) begin
         modelReady <= 1'b1;
         modelCount <= 0;
      end else if (modelReady && TX_SEND) begin
         modelReady <= 1'b0;
         modelCount <= 7;
      end else if (modelCount != 0) begin
         modelCount <= modelCount - 1;
         if (modelCount == 1) modelReady <= 1'b1;
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic pushLine(input logic [15:0] score);
      int v;
      v = int'(score);
      expQ.push_back(8'h53);
      expQ.push_back(8'h3D);
      expQ.push_back(8'h30 + 8'(v / 10000));
      expQ.push_back(8'h30 + 8'((v / 1000) % 10));
      expQ.push_back(8'h30 + 8'((v / 100) % 10));
      expQ.push_back(8'h30 + 8'((v / 10) % 10));
      expQ.push_back(8'h30 + 8'(v % 10));
      expQ.push_back(8'h0D);
      expQ.push_back(8'h0A);
   endtask

   // Called at a falling edge; that cycle becomes cycle 0 of the request.
   task automatic applyStimulus(input logic [15:0] score);
      SCORE = score;
      START = 1'b1;
      pushLine(score);
   endtask

   // Observes one line cycle by cycle until the cycle after DONE or the budget runs out.
   task automatic collectLine(input int budget, input int pulseCycle, input logic [15:0] pulseScore);
      obsBytes.delete();
      obsCycles.delete();
      obsReady.delete();
      doneCycle     = -1;
      doneCount     = 0;
      busyDropped   = 1'b0;
      busyAfterDone = 1'bx;
      for (int cyc = 1; cyc <= budget; cyc++) begin
         @(negedge CLK);
         if (cyc == 1) START = 1'b0;
         if (cyc == pulseCycle) begin
            START = 1'b1;
            SCORE = pulseScore;
         end
         if (cyc == pulseCycle + 1) START = 1'b0;
         if (TX_SEND === 1'b1) begin
            obsBytes.push_back(TX_DATA);
            obsCycles.push_back(cyc);
            obsReady.push_back(TX_READY);
         end
         if (DONE === 1'b1) begin
            doneCount++;
            if (doneCycle < 0) doneCycle = cyc;
         end
         if ((doneCycle < 0 || cyc == doneCycle) && BUSY !== 1'b1) busyDropped = 1'b1;
         if (doneCycle >= 0 && cyc == doneCycle + 1) begin
            busyAfterDone = BUSY;
            break;
         end
      end
   endtask

   task automatic test_reset();
      RST_N = 1'b0;
      repeat (3) @(negedge CLK);
      checks++; if (TX_SEND !== 1'b0) begin failures++; $display("[TB] FAIL reset_tx_send: got %b expected 0", TX_SEND); end
      checks++; if (TX_DATA !== 8'h00) begin failures++; $display("[TB] FAIL reset_tx_data: got %h expected 00", TX_DATA); end
      checks++; if (BUSY !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", BUSY); end
      checks++; if (DONE !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %b expected 0", DONE); end
      RST_N = 1'b1;
      repeat (2) @(negedge CLK);
      checks++; if (BUSY !== 1'b0) begin failures++; $display("[TB] FAIL idle_busy: got %b expected 0", BUSY); end
   endtask

   task automatic test_zero_line();
      logic [7:0] expByte;
      expQ.delete();
      useModel   = 1'b0;
      readyLevel = 1'b1;
      applyStimulus(16'd0);
      collectLine(120, 0, 16'd0);
      checks++; if (obsBytes.size() != 9) begin failures++; $display("[TB] FAIL zero_count: got %0d strobes expected 9", obsBytes.size()); end
      for (int i = 0; i < obsBytes.size(); i++) begin
         expByte = 8'hxx;
         if (expQ.size() != 0) expByte = expQ.pop_front();
         checks++; if (obsBytes[i] !== expByte) begin failures++; $display("[TB] FAIL zero_byte%0d: got %h expected %h", i, obsBytes[i], expByte); end
      end
      if (obsCycles.size() > 0) begin
         checks++; if (obsCycles[0] != 18) begin failures++; $display("[TB] FAIL zero_first_strobe: got cycle %0d expected 18", obsCycles[0]); end
      end
      for (int i = 1; i < obsCycles.size(); i++) begin
         checks++; if (obsCycles[i] - obsCycles[i-1] != 3) begin failures++; $display("[TB] FAIL zero_spacing%0d: got %0d expected 3", i, obsCycles[i] - obsCycles[i-1]); end
      end
      checks++; if (doneCycle != 44) begin failures++; $display("[TB] FAIL zero_done_cycle: got %0d expected 44", doneCycle); end
      checks++; if (doneCount != 1) begin failures++; $display("[TB] FAIL zero_done_count: got %0d expected 1", doneCount); end
      checks++; if (busyDropped !== 1'b0) begin failures++; $display("[TB] FAIL zero_busy_held: got drop=%b expected 0", busyDropped); end
      checks++; if (busyAfterDone !== 1'b0) begin failures++; $display("[TB] FAIL zero_busy_fall: got %b expected 0", busyAfterDone); end
   endtask

   task automatic test_max_with_model();
      logic [7:0] expByte;
      int         readyLow;
      expQ.delete();
      useModel = 1'b1;
      applyStimulus(16'hFFFF);
      collectLine(400, 0, 16'd0);
      checks++; if (obsBytes.size() != 9) begin failures++; $display("[TB] FAIL max_count: got %0d strobes expected 9", obsBytes.size()); end
      readyLow = 0;
      for (int i = 0; i < obsBytes.size(); i++) begin
         expByte = 8'hxx;
         if (expQ.size() != 0) expByte = expQ.pop_front();
         checks++; if (obsBytes[i] !== expByte) begin failures++; $display("[TB] FAIL max_byte%0d: got %h expected %h", i, obsBytes[i], expByte); end
         if (obsReady[i] !== 1'b1) readyLow++;
      end
      checks++; if (readyLow != 0) begin failures++; $display("[TB] FAIL max_ready_at_send: got %0d strobes without READY expected 0", readyLow); end
      checks++; if (doneCount != 1) begin failures++; $display("[TB] FAIL max_done_count: got %0d expected 1", doneCount); end
      useModel = 1'b0;
   endtask

   task automatic test_ignore_start();
      logic [7:0] expByte;
      int         extra;
      int         busyHigh;
      expQ.delete();
      readyLevel = 1'b1;
      applyStimulus(16'd1234);
      collectLine(120, 40, 16'd9999);
      checks++; if (obsBytes.size() != 9) begin failures++; $display("[TB] FAIL ignore_count: got %0d strobes expected 9", obsBytes.size()); end
      for (int i = 0; i < obsBytes.size(); i++) begin
         expByte = 8'hxx;
         if (expQ.size() != 0) expByte = expQ.pop_front();
         checks++; if (obsBytes[i] !== expByte) begin failures++; $display("[TB] FAIL ignore_byte%0d: got %h expected %h", i, obsBytes[i], expByte); end
      end
      checks++; if (busyDropped !== 1'b0) begin failures++; $display("[TB] FAIL ignore_busy_held: got drop=%b expected 0", busyDropped); end
      extra    = 0;
      busyHigh = 0;
      for (int cyc = 0; cyc < 30; cyc++) begin
         @(negedge CLK);
         if (TX_SEND === 1'b1) extra++;
         if (BUSY !== 1'b0) busyHigh++;
      end
      checks++; if (extra != 0) begin failures++; $display("[TB] FAIL ignore_extra_strobes: got %0d expected 0", extra); end
      checks++; if (busyHigh != 0) begin failures++; $display("[TB] FAIL ignore_not_queued: got %0d busy cycles expected 0", busyHigh); end
   endtask

   task automatic test_stall();
      logic [7:0] expByte;
      logic [7:0] heldData;
      int         stallStrobes;
      int         toggles;
      expQ.delete();
      readyLevel = 1'b0;
      applyStimulus(16'd7);
      stallStrobes = 0;
      toggles      = 0;
      heldData     = TX_DATA;
      for (int cyc = 1; cyc <= 516; cyc++) begin
         @(negedge CLK);
         if (cyc == 1) START = 1'b0;
         if (TX_SEND !== 1'b0) stallStrobes++;
         if (TX_DATA !== heldData) toggles++;
      end
      checks++; if (stallStrobes != 0) begin failures++; $display("[TB] FAIL stall_no_strobe: got %0d strobes expected 0", stallStrobes); end
      checks++; if (toggles != 0) begin failures++; $display("[TB] FAIL stall_data_stable: got %0d changes expected 0", toggles); end
      readyLevel = 1'b1;
      @(negedge CLK);
      expByte = expQ.pop_front();
      checks++; if (TX_SEND !== 1'b1) begin failures++; $display("[TB] FAIL stall_release_strobe: got %b expected 1", TX_SEND); end
      checks++; if (TX_DATA !== expByte) begin failures++; $display("[TB] FAIL stall_release_data: got %h expected %h", TX_DATA, expByte); end
      collectLine(100, 0, 16'd0);
      checks++; if (obsBytes.size() != 8) begin failures++; $display("[TB] FAIL stall_rest_count: got %0d strobes expected 8", obsBytes.size()); end
      for (int i = 0; i < obsBytes.size(); i++) begin
         expByte = 8'hxx;
         if (expQ.size() != 0) expByte = expQ.pop_front();
         checks++; if (obsBytes[i] !== expByte) begin failures++; $display("[TB] FAIL stall_byte%0d: got %h expected %h", i + 1, obsBytes[i], expByte); end
      end
      checks++; if (doneCount != 1) begin failures++; $display("[TB] FAIL stall_done_count: got %0d expected 1", doneCount); end
   endtask

   task automatic test_reset_midline();
      logic [7:0] expByte;
      int         seen;
      int         extra;
      int         busyHigh;
      expQ.delete();
      readyLevel = 1'b1;
      applyStimulus(16'd5555);
      seen = 0;
      for (int cyc = 1; cyc <= 60; cyc++) begin
         @(negedge CLK);
         if (cyc == 1) START = 1'b0;
         if (TX_SEND === 1'b1) begin
            expByte = expQ.pop_front();
            checks++; if (TX_DATA !== expByte) begin failures++; $display("[TB] FAIL midline_byte%0d: got %h expected %h", seen, TX_DATA, expByte); end
            seen++;
            if (seen == 4) break;
         end
      end
      checks++; if (seen != 4) begin failures++; $display("[TB] FAIL midline_strobes: got %0d expected 4", seen); end
      RST_N = 1'b0;
      @(negedge CLK);
      RST_N = 1'b1;
      checks++; if (TX_SEND !== 1'b0) begin failures++; $display("[TB] FAIL midline_tx_send: got %b expected 0", TX_SEND); end
      checks++; if (BUSY !== 1'b0) begin failures++; $display("[TB] FAIL midline_busy: got %b expected 0", BUSY); end
      checks++; if (TX_DATA !== 8'h00) begin failures++; $display("[TB] FAIL midline_tx_data: got %h expected 00", TX_DATA); end
      extra    = 0;
      busyHigh = 0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         @(negedge CLK);
         if (TX_SEND !== 1'b0) extra++;
         if (BUSY !== 1'b0) busyHigh++;
      end
      checks++; if (extra != 0 || busyHigh != 0) begin failures++; $display("[TB] FAIL midline_abandoned: got %0d strobes %0d busy cycles expected 0 and 0", extra, busyHigh); end
      expQ.delete();
      applyStimulus(16'd42);
      collectLine(120, 0, 16'd0);
      checks++; if (obsBytes.size() != 9) begin failures++; $display("[TB] FAIL after_reset_count: got %0d strobes expected 9", obsBytes.size()); end
      for (int i = 0; i < obsBytes.size(); i++) begin
         expByte = 8'hxx;
         if (expQ.size() != 0) expByte = expQ.pop_front();
         checks++; if (obsBytes[i] !== expByte) begin failures++; $display("[TB] FAIL after_reset_byte%0d: got %h expected %h", i, obsBytes[i], expByte); end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] expByte;
      expQ.delete();
      readyLevel = 1'b1;
      applyStimulus(16'd31337);
      collectLine(120, 0, 16'd0);
      checks++; if (busyAfterDone !== 1'b0) begin failures++; $display("[TB] FAIL b2b_first_idle: got busy %b expected 0", busyAfterDone); end
      for (int i = 0; i < obsBytes.size(); i++) begin
         expByte = 8'hxx;
         if (expQ.size() != 0) expByte = expQ.pop_front();
         checks++; if (obsBytes[i] !== expByte) begin failures++; $display("[TB] FAIL b2b_first_byte%0d: got %h expected %h", i, obsBytes[i], expByte); end
      end
      applyStimulus(16'd2024);
      collectLine(120, 0, 16'd0);
      checks++; if (obsBytes.size() != 9) begin failures++; $display("[TB] FAIL b2b_second_count: got %0d strobes expected 9", obsBytes.size()); end
      if (obsCycles.size() > 0) begin
         checks++; if (obsCycles[0] != 18) begin failures++; $display("[TB] FAIL b2b_second_first_strobe: got cycle %0d expected 18", obsCycles[0]); end
      end
      for (int i = 0; i < obsBytes.size(); i++) begin
         expByte = 8'hxx;
         if (expQ.size() != 0) expByte = expQ.pop_front();
         checks++; if (obsBytes[i] !== expByte) begin failures++; $display("[TB] FAIL b2b_second_byte%0d: got %h expected %h", i, obsBytes[i], expByte); end
      end
      checks++; if (doneCount != 1) begin failures++; $display("[TB] FAIL b2b_second_done: got %0d expected 1", doneCount); end
   endtask

   initial begin
      checks     = 0;
      failures   = 0;
      RST_N      = 1'b0;
      START      = 1'b0;
      SCORE      = 16'd0;
      readyLevel = 1'b1;
      useModel   = 1'b0;
      @(negedge CLK);
      test_reset();
      test_zero_line();
      test_max_with_model();
      test_ignore_start();
      test_stall();
      test_reset_midline();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
